// File: rtl/arb_pkg.sv
// Shared types and width helpers for the request arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_e;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface req_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]           REQ;
  logic [NREQ-1:0]           GNT;
  logic [id_width(NREQ)-1:0] GNT_ID;
  logic                      VLD;
  logic                      TIMEOUT;

  modport master (
    output REQ,
    input  GNT,
    input  GNT_ID,
    input  VLD,
    input  TIMEOUT
  );

  modport slave (
    input  REQ,
    output GNT,
    output GNT_ID,
    output VLD,
    output TIMEOUT
  );

endinterface

// File: rtl/req_prio_sel.sv
// Combinational first-set-bit search over a request vector, starting at start_i and
// walking ascending or descending with wrap-around.
module req_prio_sel
  import arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter bit          Ascending = 1'b0,
  localparam int unsigned IdW      = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  start_i,
  output logic [IdW-1:0]  idx_o,
  output logic            found_o
);

  int unsigned j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = Ascending ? (32'(start_i) + k) % NREQ : (32'(start_i) + NREQ - k) % NREQ;
      if (!found_o && req_i[j[IdW-1:0]]) begin
        idx_o   = j[IdW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Registered one-hot arbiter with grant hold and hold-time limit.
// REQ_ARBITER_ROUND_ROBIN_EN selects rotating priority instead of highest-index-wins + masking.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst,
  req_arbiter_if.slave arb_io
);

  localparam int unsigned IdW  = id_width(NREQ);
  localparam int unsigned CntW = cnt_width(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IdW-1:0]   id_q, id_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

  logic [NREQ-1:0]  cand;
  logic [IdW-1:0]   start;
  logic [IdW-1:0]   win_idx;
  logic             win_found;

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
  logic [IdW-1:0]   ptr_q, ptr_d;

  assign cand  = arb_io.REQ;
  assign start = IdW'((32'(ptr_q) + 1) % NREQ);

  req_prio_sel #(
    .NREQ      (NREQ),
    .Ascending (1'b1)
  ) u_sel (
    .req_i   (cand),
    .start_i (start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );
`else
  logic [NREQ-1:0]  mask_q, mask_d;

  // A masked-out sole requester still wins: fall back to the raw vector.
  assign cand  = ((arb_io.REQ & ~mask_q) != '0) ? (arb_io.REQ & ~mask_q) : arb_io.REQ;
  assign start = IdW'(NREQ - 1);

  req_prio_sel #(
    .NREQ      (NREQ),
    .Ascending (1'b0)
  ) u_sel (
    .req_i   (cand),
    .start_i (start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`else
    mask_d  = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          id_d           = win_idx;
          vld_d          = 1'b1;
          cnt_d          = CntW'(1);
          state_d        = BUSY;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
          ptr_d          = win_idx;
`else
          mask_d         = '0;
`endif
        end
      end
      BUSY: begin
        if (!arb_io.REQ[id_q]) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
`ifndef REQ_ARBITER_ROUND_ROBIN_EN
          mask_d  = '0;
`endif
        end else if (cnt_q == CntW'(MAX_HOLD)) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          to_d    = 1'b1;
          state_d = IDLE;
`ifndef REQ_ARBITER_ROUND_ROBIN_EN
          mask_d       = '0;
          mask_d[id_q] = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= IdW'(NREQ - 1);
`else
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`else
      mask_q  <= mask_d;
`endif
    end
  end

  assign arb_io.GNT     = gnt_q;
  assign arb_io.GNT_ID  = id_q;
  assign arb_io.VLD     = vld_q;
  assign arb_io.TIMEOUT = to_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed-vector bench for req_arbiter (NREQ=4, MAX_HOLD=8).
module tb_req_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  req_arbiter_if #(.NREQ(NREQ)) bus ();

  req_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_io (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] gnt, input logic vld,
                           input logic to, input logic [1:0] id);
    check_eq({tag, ".gnt"}, 32'(bus.GNT), 32'(gnt));
    check_eq({tag, ".vld"}, 32'(bus.VLD), 32'(vld));
    check_eq({tag, ".to"},  32'(bus.TIMEOUT), 32'(to));
    if (vld) check_eq({tag, ".id"}, 32'(bus.GNT_ID), 32'(id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    bus.REQ = 4'b1111;

    // Reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("rst", 4'b0000, 1'b0, 1'b0, 2'd0);
    end
    rst = 1'b0;
    step();
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    check_out("first", 4'b0001, 1'b1, 1'b0, 2'd0);
`else
    check_out("first", 4'b1000, 1'b1, 1'b0, 2'd3);
`endif
    bus.REQ = 4'b0000;
    step();
    check_out("first_rel", 4'b0000, 1'b0, 1'b0, 2'd0);
    step();

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    // Rotation after first grant to 0: next search starts at 1
    bus.REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < int'(MAX_HOLD); c++) begin
        step();
        check_out("rr_hold", 4'(1 << ((g + 1) % 4)), 1'b1, 1'b0, 2'((g + 1) % 4));
      end
      step();
      check_out("rr_to", 4'b0000, 1'b0, 1'b1, 2'd0);
    end
    bus.REQ = 4'b0000;
    step();
`else
    // Priority and normal release
    bus.REQ = 4'b0101;
    step();
    check_out("prio", 4'b0100, 1'b1, 1'b0, 2'd2);
    step();
    step();
    check_out("prio_hold", 4'b0100, 1'b1, 1'b0, 2'd2);
    bus.REQ = 4'b0001;
    step();
    check_out("prio_rel", 4'b0000, 1'b0, 1'b0, 2'd0);
    step();
    check_out("prio_next", 4'b0001, 1'b1, 1'b0, 2'd0);
    bus.REQ = 4'b0000;
    step();
    check_out("prio_idle", 4'b0000, 1'b0, 1'b0, 2'd0);
    step();

    // Timeout with contention: masked holder yields to requester 1
    bus.REQ = 4'b1010;
    for (int c = 0; c < int'(MAX_HOLD); c++) begin
      step();
      check_out("cont_hold", 4'b1000, 1'b1, 1'b0, 2'd3);
    end
    step();
    check_out("cont_to", 4'b0000, 1'b0, 1'b1, 2'd0);
    step();
    check_out("cont_next", 4'b0010, 1'b1, 1'b0, 2'd1);
    bus.REQ = 4'b0000;
    step();
    step();

    // Timeout, sole requester: mask falls back to raw REQ
    bus.REQ = 4'b1000;
    for (int c = 0; c < int'(MAX_HOLD); c++) begin
      step();
      check_out("sole_hold", 4'b1000, 1'b1, 1'b0, 2'd3);
    end
    step();
    check_out("sole_to", 4'b0000, 1'b0, 1'b1, 2'd0);
    step();
    check_out("sole_again", 4'b1000, 1'b1, 1'b0, 2'd3);
    bus.REQ = 4'b0000;
    step();
    step();

    // Reset mid-grant, then a full-length hold proves the counter restarted
    bus.REQ = 4'b0100;
    for (int c = 0; c < 3; c++) step();
    check_out("mid_pre", 4'b0100, 1'b1, 1'b0, 2'd2);
    rst = 1'b1;
    step();
    check_out("mid_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    step();
    check_out("mid_regrant", 4'b0100, 1'b1, 1'b0, 2'd2);
    for (int c = 1; c < int'(MAX_HOLD); c++) begin
      // Non-granted bits toggle without effect
      bus.REQ = 4'b0100 | 4'(((c & 1) << 3) | ((c & 2) >> 1));
      step();
      check_out("mid_hold", 4'b0100, 1'b1, 1'b0, 2'd2);
    end
    bus.REQ = 4'b0100;
    step();
    check_out("mid_to", 4'b0000, 1'b0, 1'b1, 2'd0);
    bus.REQ = 4'b0000;
    step();
    check_out("mid_idle", 4'b0000, 1'b0, 1'b0, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
